// File: rtl/multicycle_adder_pkg.sv
// Shared types and helpers for the multi-cycle ripple adder.
// The state encoding and counter sizing are used by the top and the bench.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width: clog2(n), but never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// Request/result bundle between an arithmetic client and the multi-cycle adder.
// The client drives start/operands; the adder returns status and the result.
interface multicycle_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/multicycle_adder_full_adder_cell.sv
// One-bit combinational full adder; chained DIGIT-wide inside the adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  logic w_half;

  assign w_half = a ^ b;
  assign sum    = w_half ^ c;
  assign carry  = (a & b) | (c & w_half);
endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle ripple adder: DIGIT bits per clock through a full-adder chain,
// with a registered carry between digits and a one-cycle done pulse.
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("multicycle_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT:0]   w_c;
  logic [DIGIT-1:0] w_dsum;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;
  logic             w_accept;

  assign w_c[0] = r_carry;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
    full_adder_cell u_cell (
      .a     (r_a[gi]),
      .b     (r_b[gi]),
      .c     (w_c[gi]),
      .sum   (w_dsum[gi]),
      .carry (w_c[gi+1])
    );
  end

  // Digits enter at the MSB end so the LSB digit lands in place after N shifts.
  assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_dsum) << (WIDTH - DIGIT));
  assign w_last     = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= bus.cin;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_c[DIGIT];
      r_acc   <= w_acc_next;
      r_cnt   <= r_cnt + CW'(1);
      // Results are published only once, on the final digit.
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_c[DIGIT];
        r_ovf  <= w_c[DIGIT] ^ w_c[DIGIT-1];
      end
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule
